zion_riscv_isa_lib_add_sub_decode: RTL and testbench
====================================================

// Module: zion_riscv_isa_lib_add_sub_decode
// PURPOSE
//   Decode stage directly upstream of the AddSub execute unit. Takes one RISC-V instruction plus its rs1/rs2
//   operand values and produces the execute unit's op/s1/s2 inputs and the LessThan control flags.
//   Registered, 1-cycle latency, valid/ready handshake on both sides.
//   A 2-entry skid buffer lets iRdy (downstream) stall with no loss and no bubble.
// PARAMETERS
//   RV64   0   1: RV64I (OP-32 / OP-IMM-32 decoded, XLEN=64); 0: RV32I (XLEN=32)
// PORTS
//   clk            in   1          clock, all state on rising edge
//   rst_n          in   1          asynchronous active-low reset
//   iFlush         in   1          synchronous flush of both buffer entries
//   iVld           in   1          upstream instruction valid
//   oRdy           out  1          this stage can accept (registered, = !skid entry valid)
//   iInst          in   32         instruction word
//   iRs1Val        in   XLEN       rs1 operand value
//   iRs2Val        in   XLEN       rs2 operand value
//   oVld           out  1          output entry valid
//   iRdy           in   1          downstream (execute) ready
//   oOp            out  RV64+2     op[0]=add, op[1]=sub, op[2]=.W (RV64 only)
//   oS1, oS2       out  XLEN       execute operands
//   oHit           out  1          instruction belongs to AddSub/LessThan group
//   oLtFlg         out  1          result consumed as less-than (SLT*/branch)
//   oUnsignedFlg   out  1          unsigned compare (SLTU, SLTIU, BLTU, BGEU)
//   oBrInvFlg      out  1          branch taken = !lessThan (BGE, BGEU)
// BEHAVIOUR
//   Reset: oVld=0, oRdy=1, all data/flag outputs 0. Skid entry invalid.
//   Decode (opcode, funct3, funct7), immI = sext(inst[31:20]):
//     0110011 f3=000 f7=0000000 ADD  -> op=add, s2=rs2
//     0110011 f3=000 f7=0100000 SUB  -> op=sub, s2=rs2
//     0110011 f3=010/011 f7=0 SLT/SLTU -> op=sub, lt=1, unsigned=f3[0], s2=rs2
//     0010011 f3=000 ADDI -> op=add, s2=immI. f3=010/011 SLTI/SLTIU -> op=sub, lt=1, unsigned=f3[0], s2=immI
//     1100011 f3=100/101/110/111 BLT/BGE/BLTU/BGEU -> op=sub, lt=1, unsigned=f3[1], brInv=f3[0], s2=rs2
//     RV64 only: 0111011 ADDW/SUBW (f7 as ADD/SUB) and 0011011 f3=000 ADDIW -> op[2]=1 plus add/sub
//     s1=rs1 for every hit. All else (incl. OP-32 when RV64=0): oHit=0, op=0, flags=0, s1=s2=0.
//     Non-hits still flow through the handshake. op[0] and op[1] are never both 1.
//   Handshake: input accepted when iVld&&oRdy. Output transfer when oVld&&iRdy.
//     Main reg empty, or transferring this cycle: the accepted instruction loads into main next cycle.
//       If the skid entry is valid, skid moves to main first and the new input goes to skid.
//     Main full and not transferring: the accepted input loads into skid; oRdy=0 from the next cycle.
//     Skid valid and main transfers with no input: skid -> main, oRdy=1 next cycle.
//   Latency: accepted at edge N -> oVld at N+1 when the buffer was empty. Full throughput with iRdy=1.
//   Output data is held stable while oVld && !iRdy.
//   iFlush: both entries invalid next cycle, oVld=0, oRdy=1. Any input accepted in the flush cycle is dropped.
//     iFlush has priority over every transfer.
//   Reset mid-operation: immediately (async) returns to reset values; no partial entry survives.
//   Buffer never holds more than 2 entries. Accept while full is impossible since oRdy=0.
// TESTING
//   1. RV32, ADD x,rs1=5,rs2=7, iRdy=1 -> next cycle oVld=1, oOp=01, oS1=5, oS2=7, oHit=1, oLtFlg=0.
//   2. RV32, SLTIU imm=0xFFF, rs1=3 -> oOp=10, oS2=0xFFFFFFFF, oLtFlg=1, oUnsignedFlg=1.
//   3. RV64, ADDIW imm=-1 -> oOp=101, oS2=64'hFFFF_FFFF_FFFF_FFFF. With RV64=0 the same opcode gives oHit=0, oOp=0.
//   4. BGEU back-to-back 3 instrs, iRdy=0 -> oRdy falls after the 2nd accept; iRdy=1 -> in-order drain A,B,C, no loss or duplication.
//   5. Buffer full, iFlush=1 with iVld=1 -> next cycle oVld=0, oRdy=1, nothing emitted.
//   6. rst_n low mid-stream with 2 entries held -> oVld=0, oRdy=1 asynchronously. First post-reset input emerges after 1 cycle.

Source files
------------

// File: rtl/zion_riscv_isa_lib_add_sub_decode.sv
// Decode stage feeding the AddSub execute unit: decodes ADD/SUB/SLT*/branch-compare
// instructions into op/operands/flags behind a 2-entry skid buffer with valid/ready on both sides.
module zion_riscv_isa_lib_add_sub_decode #(
    parameter  int RV64 = 0,
    localparam int XLEN = (RV64 != 0) ? 64 : 32,
    localparam int OPW  = RV64 + 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            iFlush,
    input  logic            iVld,
    output logic            oRdy,
    input  logic [31:0]     iInst,
    input  logic [XLEN-1:0] iRs1Val,
    input  logic [XLEN-1:0] iRs2Val,
    output logic            oVld,
    input  logic            iRdy,
    output logic [OPW-1:0]  oOp,
    output logic [XLEN-1:0] oS1,
    output logic [XLEN-1:0] oS2,
    output logic            oHit,
    output logic            oLtFlg,
    output logic            oUnsignedFlg,
    output logic            oBrInvFlg
);

    typedef struct packed {
        logic [OPW-1:0]  op;
        logic [XLEN-1:0] s1;
        logic [XLEN-1:0] s2;
        logic            hit;
        logic            lt;
        logic            uns;
        logic            inv;
    } entry_t;

    logic [6:0]      opcode;
    logic [2:0]      f3;
    logic [6:0]      f7;
    logic [XLEN-1:0] imm;
    logic [2:0]      dec_op3;
    logic            dec_use_imm;
    logic            dec_hit;
    logic            dec_lt;
    logic            dec_uns;
    logic            dec_inv;
    entry_t          dec;

    entry_t main_q, main_d, skid_q, skid_d;
    logic   main_vld_q, main_vld_d, skid_vld_q, skid_vld_d;
    logic   acc, xfer;

    // rd/rs field bits are not needed here; op[2] is dropped when RV64=0
    logic unused_ok;
    assign unused_ok = ^{iInst[19:15], iInst[11:7], dec_op3};

    assign opcode = iInst[6:0];
    assign f3     = iInst[14:12];
    assign f7     = iInst[31:25];
    assign imm    = {{(XLEN-12){iInst[31]}}, iInst[31:20]};

    always_comb begin
        dec_op3     = 3'b000;
        dec_use_imm = 1'b0;
        dec_hit     = 1'b0;
        dec_lt      = 1'b0;
        dec_uns     = 1'b0;
        dec_inv     = 1'b0;
        case (opcode)
            7'b0110011: begin
                if (f3 == 3'b000 && f7 == 7'b0000000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b001;
                end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b010;
                end else if (f3[2:1] == 2'b01 && f7 == 7'b0000000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b010; dec_lt = 1'b1; dec_uns = f3[0];
                end
            end
            7'b0010011: begin
                if (f3 == 3'b000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b001; dec_use_imm = 1'b1;
                end else if (f3[2:1] == 2'b01) begin
                    dec_hit = 1'b1; dec_op3 = 3'b010; dec_use_imm = 1'b1;
                    dec_lt  = 1'b1; dec_uns = f3[0];
                end
            end
            7'b1100011: begin
                // BLT/BGE/BLTU/BGEU: f3[1] selects unsigned, f3[0] inverts the taken sense
                if (f3[2]) begin
                    dec_hit = 1'b1; dec_op3 = 3'b010; dec_lt = 1'b1;
                    dec_uns = f3[1]; dec_inv = f3[0];
                end
            end
            7'b0111011: begin
                if (RV64 != 0 && f3 == 3'b000 && f7 == 7'b0000000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b101;
                end else if (RV64 != 0 && f3 == 3'b000 && f7 == 7'b0100000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b110;
                end
            end
            7'b0011011: begin
                if (RV64 != 0 && f3 == 3'b000) begin
                    dec_hit = 1'b1; dec_op3 = 3'b101; dec_use_imm = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        dec.op  = dec_op3[OPW-1:0];
        dec.s1  = dec_hit ? iRs1Val : '0;
        dec.s2  = dec_hit ? (dec_use_imm ? imm : iRs2Val) : '0;
        dec.hit = dec_hit;
        dec.lt  = dec_lt;
        dec.uns = dec_uns;
        dec.inv = dec_inv;
    end

    assign acc  = iVld && !skid_vld_q;
    assign xfer = main_vld_q && iRdy;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;
        if (iFlush) begin
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || xfer) begin
            // main frees up: the older skid entry advances before any new input
            if (skid_vld_q) begin
                main_d     = skid_q;
                main_vld_d = 1'b1;
                skid_vld_d = acc;
                if (acc) skid_d = dec;
            end else begin
                main_vld_d = acc;
                if (acc) main_d = dec;
            end
        end else if (acc) begin
            skid_d     = dec;
            skid_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
        end
    end

    assign oRdy         = !skid_vld_q;
    assign oVld         = main_vld_q;
    assign oOp          = main_q.op;
    assign oS1          = main_q.s1;
    assign oS2          = main_q.s2;
    assign oHit         = main_q.hit;
    assign oLtFlg       = main_q.lt;
    assign oUnsignedFlg = main_q.uns;
    assign oBrInvFlg    = main_q.inv;

endmodule

// File: tb/tb_zion_riscv_isa_lib_add_sub_decode.sv
// Scoreboard bench: RV32 and RV64 instances share the handshake stimulus; expected
// decodes come from an independent reference model and are queued on every accept.
module tb_zion_riscv_isa_lib_add_sub_decode;

    typedef struct packed {
        logic [2:0]  op;
        logic [63:0] s1;
        logic [63:0] s2;
        logic        hit;
        logic        lt;
        logic        uns;
        logic        inv;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        iFlush, iVld, iRdy;
    logic [31:0] iInst;
    logic [63:0] rs1, rs2;

    logic        oRdy32, oVld32, hit32, lt32, uns32, inv32;
    logic [1:0]  op32;
    logic [31:0] s1_32, s2_32;
    logic        oRdy64, oVld64, hit64, lt64, uns64, inv64;
    logic [2:0]  op64;
    logic [63:0] s1_64, s2_64;

    exp_t q32[$];
    exp_t q64[$];
    int   n_cmp = 0;
    int   n_err = 0;
    logic [31:0] tbl[16];

    always #5 clk = ~clk;

    zion_riscv_isa_lib_add_sub_decode #(.RV64(0)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy32),
        .iInst(iInst), .iRs1Val(rs1[31:0]), .iRs2Val(rs2[31:0]), .oVld(oVld32), .iRdy(iRdy),
        .oOp(op32), .oS1(s1_32), .oS2(s2_32), .oHit(hit32), .oLtFlg(lt32),
        .oUnsignedFlg(uns32), .oBrInvFlg(inv32)
    );

    zion_riscv_isa_lib_add_sub_decode #(.RV64(1)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .iFlush(iFlush), .iVld(iVld), .oRdy(oRdy64),
        .iInst(iInst), .iRs1Val(rs1), .iRs2Val(rs2), .oVld(oVld64), .iRdy(iRdy),
        .oOp(op64), .oS1(s1_64), .oS2(s2_64), .oHit(hit64), .oLtFlg(lt64),
        .oUnsignedFlg(uns64), .oBrInvFlg(inv64)
    );

    task automatic chk(input string tag, input logic [139:0] got, input logic [139:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] a,
                                   input logic [63:0] b, input bit rv64);
        exp_t e;
        logic [6:0] opc;
        logic [2:0] fn3;
        logic [6:0] fn7;
        logic [63:0] im;
        bit use_im;
        e = '0;
        use_im = 0;
        opc = ins[6:0];
        fn3 = ins[14:12];
        fn7 = ins[31:25];
        im  = {{52{ins[31]}}, ins[31:20]};
        case (opc)
            7'h33: begin
                if (fn3 == 0 && fn7 == 7'h00) begin e.hit = 1; e.op = 3'b001; end
                if (fn3 == 0 && fn7 == 7'h20) begin e.hit = 1; e.op = 3'b010; end
                if ((fn3 == 2 || fn3 == 3) && fn7 == 7'h00) begin
                    e.hit = 1; e.op = 3'b010; e.lt = 1; e.uns = (fn3 == 3);
                end
            end
            7'h13: begin
                if (fn3 == 0) begin e.hit = 1; e.op = 3'b001; use_im = 1; end
                if (fn3 == 2 || fn3 == 3) begin
                    e.hit = 1; e.op = 3'b010; e.lt = 1; e.uns = (fn3 == 3); use_im = 1;
                end
            end
            7'h63: begin
                if (fn3 >= 4) begin
                    e.hit = 1; e.op = 3'b010; e.lt = 1;
                    e.uns = (fn3 == 6 || fn3 == 7); e.inv = (fn3 == 5 || fn3 == 7);
                end
            end
            7'h3B: begin
                if (rv64 && fn3 == 0 && fn7 == 7'h00) begin e.hit = 1; e.op = 3'b101; end
                if (rv64 && fn3 == 0 && fn7 == 7'h20) begin e.hit = 1; e.op = 3'b110; end
            end
            7'h1B: begin
                if (rv64 && fn3 == 0) begin e.hit = 1; e.op = 3'b101; use_im = 1; end
            end
            default: ;
        endcase
        if (e.hit) begin
            e.s1 = a;
            e.s2 = use_im ? im : b;
        end
        return e;
    endfunction

    // one clock: drive at negedge, check occupancy and any output transfer, then book the accept
    task automatic step(input logic v, input logic [31:0] ins, input logic [63:0] a,
                        input logic [63:0] b, input logic r, input logic f);
        exp_t e;
        @(negedge clk);
        iVld = v; iInst = ins; rs1 = a; rs2 = b; iRdy = r; iFlush = f;
        #1;
        chk("vld32", oVld32, q32.size() != 0);
        chk("rdy32", oRdy32, q32.size() < 2);
        chk("vld64", oVld64, q64.size() != 0);
        chk("rdy64", oRdy64, q64.size() < 2);
        if (oVld32 && iRdy && q32.size() != 0) begin
            e = q32.pop_front();
            chk("data32", {op32, s1_32, s2_32, hit32, lt32, uns32, inv32},
                {e.op[1:0], e.s1[31:0], e.s2[31:0], e.hit, e.lt, e.uns, e.inv});
        end
        if (oVld64 && iRdy && q64.size() != 0) begin
            e = q64.pop_front();
            chk("data64", {op64, s1_64, s2_64, hit64, lt64, uns64, inv64}, e);
        end
        if (f) begin
            q32.delete();
            q64.delete();
        end else begin
            if (v && oRdy32) q32.push_back(model(ins, a, b, 1'b0));
            if (v && oRdy64) q64.push_back(model(ins, a, b, 1'b1));
        end
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 64'h0, 64'h0, r, 1'b0);
    endtask

    localparam logic [31:0] ADD   = {7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33};
    localparam logic [31:0] SLTIU = {12'hFFF, 5'd2, 3'd3, 5'd1, 7'h13};
    localparam logic [31:0] ADDIW = {12'hFFF, 5'd2, 3'd0, 5'd1, 7'h1B};
    localparam logic [31:0] BGEU  = {7'h00, 5'd3, 5'd2, 3'd7, 5'd0, 7'h63};

    initial begin
        logic [31:0] ins;
        tbl[0]  = ADD;
        tbl[1]  = {7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33};   // SUB
        tbl[2]  = {7'h00, 5'd3, 5'd2, 3'd2, 5'd1, 7'h33};   // SLT
        tbl[3]  = {7'h00, 5'd3, 5'd2, 3'd3, 5'd1, 7'h33};   // SLTU
        tbl[4]  = {12'h000, 5'd2, 3'd0, 5'd1, 7'h13};       // ADDI
        tbl[5]  = {12'h000, 5'd2, 3'd2, 5'd1, 7'h13};       // SLTI
        tbl[6]  = {7'h00, 5'd3, 5'd2, 3'd4, 5'd0, 7'h63};   // BLT
        tbl[7]  = {7'h00, 5'd3, 5'd2, 3'd5, 5'd0, 7'h63};   // BGE
        tbl[8]  = {7'h00, 5'd3, 5'd2, 3'd6, 5'd0, 7'h63};   // BLTU
        tbl[9]  = BGEU;
        tbl[10] = {7'h00, 5'd3, 5'd2, 3'd0, 5'd1, 7'h3B};   // ADDW
        tbl[11] = {7'h20, 5'd3, 5'd2, 3'd0, 5'd1, 7'h3B};   // SUBW
        tbl[12] = {12'h000, 5'd2, 3'd0, 5'd1, 7'h1B};       // ADDIW
        tbl[13] = {7'h01, 5'd3, 5'd2, 3'd0, 5'd1, 7'h33};   // MUL (miss)
        tbl[14] = {7'h00, 5'd3, 5'd2, 3'd0, 5'd0, 7'h63};   // BEQ (miss)
        tbl[15] = {7'h20, 5'd3, 5'd2, 3'd2, 5'd1, 7'h33};   // bad f7 SLT (miss)

        rst_n = 1'b0; iFlush = 1'b0; iVld = 1'b0; iRdy = 1'b0;
        iInst = '0; rs1 = '0; rs2 = '0;
        repeat (2) @(negedge clk);
        chk("rst_vld32", oVld32, 1'b0);
        chk("rst_rdy32", oRdy32, 1'b1);
        chk("rst_data32", {op32, s1_32, s2_32, hit32, lt32, uns32, inv32}, '0);
        chk("rst_data64", {op64, s1_64, s2_64, hit64, lt64, uns64, inv64}, '0);
        rst_n = 1'b1;

        // single-instruction decodes, including the RV32/RV64 split on ADDIW
        step(1'b1, ADD, 64'd5, 64'd7, 1'b1, 1'b0);
        step(1'b1, SLTIU, 64'd3, 64'd0, 1'b1, 1'b0);
        step(1'b1, ADDIW, 64'h1234, 64'h9, 1'b1, 1'b0);
        idle(2, 1'b1);

        // stall: three BGEU with downstream blocked, then in-order drain
        step(1'b1, BGEU, 64'hA, 64'h1, 1'b0, 1'b0);
        step(1'b1, BGEU, 64'hB, 64'h2, 1'b0, 1'b0);
        step(1'b1, BGEU, 64'hC, 64'h3, 1'b0, 1'b0);
        step(1'b1, BGEU, 64'hC, 64'h3, 1'b1, 1'b0);
        step(1'b1, BGEU, 64'hC, 64'h3, 1'b1, 1'b0);
        idle(3, 1'b1);

        // flush with buffer full, and flush dropping a same-cycle accept
        step(1'b1, ADD, 64'h11, 64'h22, 1'b0, 1'b0);
        step(1'b1, ADD, 64'h33, 64'h44, 1'b0, 1'b0);
        step(1'b1, ADD, 64'h55, 64'h66, 1'b0, 1'b1);
        idle(3, 1'b1);
        step(1'b1, tbl[1], 64'h77, 64'h88, 1'b0, 1'b0);
        step(1'b1, tbl[2], 64'h99, 64'hAA, 1'b0, 1'b1);
        idle(3, 1'b1);

        // async reset with two entries held
        step(1'b1, tbl[6], 64'h1, 64'h2, 1'b0, 1'b0);
        step(1'b1, tbl[7], 64'h3, 64'h4, 1'b0, 1'b0);
        @(negedge clk);
        iVld = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_vld32", oVld32, 1'b0);
        chk("async_rdy32", oRdy32, 1'b1);
        chk("async_vld64", oVld64, 1'b0);
        chk("async_rdy64", oRdy64, 1'b1);
        q32.delete();
        q64.delete();
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, tbl[3], 64'hDEAD_BEEF_0000_0001, 64'h5, 1'b1, 1'b0);
        idle(2, 1'b1);

        // random traffic over the whole table with random back-pressure
        for (int i = 0; i < 300; i++) begin
            ins = tbl[$urandom_range(0, 15)];
            if (ins[6:0] == 7'h13 || ins[6:0] == 7'h1B) ins[31:20] = 12'($urandom);
            step(1'($urandom_range(0, 3) != 0), ins, {$urandom, $urandom}, {$urandom, $urandom},
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
        end
        idle(4, 1'b1);
        chk("drain32", q32.size(), 0);
        chk("drain64", q64.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
